single_port_ram: RTL and testbench
==================================

SINGLE_PORT_RAM -- requirements
Module: single_port_ram

Interface
- REQ-001: Parameter DATA_W, default 8: data word width in bits.
- REQ-002: Parameter ADDR_W, default 8: address width in bits.
- REQ-003: Parameter DEPTH, default 2**ADDR_W (256): number of words stored.
- REQ-004: Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
- REQ-005: Port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-006: Port wr, input, 1 bit: write enable.
- REQ-007: Port rd, input, 1 bit: read enable.
- REQ-008: Port addr, input, ADDR_W bits: shared read/write word address.
- REQ-009: Port d_in, input, DATA_W bits: write data.
- REQ-010: Port d_out, output, DATA_W bits: registered read data.

Function
- REQ-011: Storage SHALL be DEPTH words of DATA_W bits, all addressed by the single port addr.
- REQ-012: wr=1 at a rising edge SHALL write d_in to mem[addr] at that edge.
- REQ-013: rd=1, wr=0 at a rising edge SHALL load d_out with mem[addr] at that edge; read latency 1 clock.
- REQ-014: rd=1, wr=1 at the same edge SHALL be write-first: mem[addr] and d_out both take d_in at that edge.
- REQ-015: rd=0 SHALL hold d_out at its previous value, regardless of wr, addr or d_in.
- REQ-016: rd=0, wr=0 SHALL leave memory and d_out unchanged.
- REQ-017: addr SHALL be used unmodified, with no wrap or offset logic.
- REQ-018: When DEPTH < 2**ADDR_W, writes to addresses >= DEPTH SHALL be ignored, and reads of them SHALL return 0.
- REQ-019: d_out SHALL be driven only from its register, never combinationally from inputs.
- REQ-020: Data and address widths SHALL pass through unchanged, with no arithmetic on data.
- REQ-021: Memory contents SHALL be X (undefined) until first written; a bench SHALL NOT rely on their initial value.

Reset
- REQ-022: rst=1 at a rising edge SHALL set d_out to 0.
- REQ-023: rst SHALL have priority over rd and wr; a write presented during reset SHALL be suppressed.
- REQ-024: rst SHALL NOT clear memory contents; words written before reset SHALL survive it.
- REQ-025: Reset asserted between a write and its readback SHALL not corrupt the written word; the first read after reset returns the stored word.

Structure
- REQ-026: A shared package spram_pkg SHALL hold the DATA_W/ADDR_W defaults and a data-word typedef.
- REQ-027: No sub-module is needed; storage and the output register SHALL be inferred inline so synthesis can map them to block RAM.

Verification
- REQ-028: Write-then-read: wr=1 with addr=0x00, d_in=0x24 for one cycle, then rd=1, wr=0 -> d_out=0x24 one edge later.
- REQ-029: Simultaneous read/write: addr=0x05 holding 0x81, then wr=1, rd=1, d_in=0x09 -> d_out=0x09 at that edge; a following plain read returns 0x09.
- REQ-030: Hold: after d_out=0x63, set rd=0 and write 0x0D to the same address -> d_out stays 0x63 until the next read.
- REQ-031: Full sweep: write a random value to each address 0x00..0xFF, then read every address -> each d_out matches the written value, with no aliasing at 0xFF/0x00.
- REQ-032: Reset: d_out=0x65, then rst=1 for one cycle with wr=1, d_in=0xAA at addr 0x10 (previously 0x12) -> d_out=0x00, and a subsequent read of 0x10 returns 0x12.

Source files
------------

// File: rtl/spram_pkg.sv
// rtl/spram_pkg.sv - shared width defaults and data-word type for the single-port RAM
package spram_pkg;

  localparam int SPRAM_DATA_W = 8;
  localparam int SPRAM_ADDR_W = 8;

  typedef logic [SPRAM_DATA_W-1:0] spram_word_t;

endpackage

// File: rtl/single_port_ram.sv
// rtl/single_port_ram.sv - single-port RAM, write-first, registered read data
module single_port_ram
  import spram_pkg::*;
#(
  parameter int DATA_W = SPRAM_DATA_W,
  parameter int ADDR_W = SPRAM_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  // Addresses past a short array are dropped on write and read back as zero.
  assign in_range = ({1'b0, addr} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
    end else begin
      if (wr && in_range) begin
        mem[addr] <= d_in;
      end
      if (rd) begin
        if (!in_range) begin
          d_out <= '0;
        end else if (wr) begin
          d_out <= d_in;
        end else begin
          d_out <= mem[addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_single_port_ram.sv
// tb/tb_single_port_ram.sv - scoreboard bench for single_port_ram (full and short-depth instances)
module tb_single_port_ram;
  import spram_pkg::*;

  localparam int SMALL_DEPTH = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  addr = '0;
  spram_word_t d_in = '0;
  spram_word_t d_out;
  spram_word_t d_out_s;

  always #5 clk = ~clk;

  single_port_ram u_dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .d_in(d_in), .d_out(d_out)
  );

  single_port_ram #(.DEPTH(SMALL_DEPTH)) u_small (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .d_in(d_in), .d_out(d_out_s)
  );

  typedef struct {
    bit          chk;
    spram_word_t v;
    bit          chk_s;
    spram_word_t vs;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: word array plus "has been written" flags.
  spram_word_t m [256];
  bit          wrote [256];
  spram_word_t mdo = '0, mdo_s = '0;
  bit          mk = 1'b0, mk_s = 1'b0;
  spram_word_t sweep_val [256];

  task automatic step(input bit r, input bit w, input bit rdn, input logic [7:0] a,
                      input spram_word_t d, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; wr = w; rd = rdn; addr = a; d_in = d;
    if (r) begin
      mdo = '0; mk = 1'b1; mdo_s = '0; mk_s = 1'b1;
    end else begin
      if (rdn) begin
        if (w) begin mdo = d; mk = 1'b1; end
        else   begin mdo = m[a]; mk = wrote[a]; end
        if (int'(a) >= SMALL_DEPTH) begin mdo_s = '0; mk_s = 1'b1; end
        else if (w) begin mdo_s = d; mk_s = 1'b1; end
        else        begin mdo_s = m[a]; mk_s = wrote[a]; end
      end
      if (w) begin m[a] = d; wrote[a] = 1'b1; end
    end
    e.chk = mk; e.v = mdo; e.chk_s = mk_s; e.vs = mdo_s; e.tag = tag;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        checks++;
        if (d_out !== e.v) begin
          errors++;
          $display("FAIL %s: d_out=%h expected %h", e.tag, d_out, e.v);
        end
      end
      if (e.chk_s) begin
        checks++;
        if (d_out_s !== e.vs) begin
          errors++;
          $display("FAIL %s(short): d_out=%h expected %h", e.tag, d_out_s, e.vs);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    for (int i = 0; i < 256; i++) wrote[i] = 1'b0;

    step(1, 0, 0, 8'h00, 8'h00, "reset");
    step(0, 0, 0, 8'h00, 8'h00, "idle");

    step(0, 1, 0, 8'h00, 8'h24, "wr00");
    step(0, 0, 1, 8'h00, 8'h00, "rd00");

    step(0, 1, 0, 8'h05, 8'h81, "wr05");
    step(0, 1, 1, 8'h05, 8'h09, "rdwr05");
    step(0, 0, 1, 8'h05, 8'h00, "rd05");

    step(0, 1, 0, 8'h20, 8'h63, "wr20");
    step(0, 0, 1, 8'h20, 8'h00, "rd20");
    step(0, 1, 0, 8'h20, 8'h0D, "hold_wr");
    step(0, 0, 0, 8'h7F, 8'hFF, "hold_idle");
    step(0, 0, 1, 8'h20, 8'h00, "rd20_new");

    step(0, 1, 0, 8'h10, 8'h12, "wr10");
    step(0, 1, 0, 8'h30, 8'h65, "wr30");
    step(0, 0, 1, 8'h30, 8'h00, "rd30");
    step(1, 1, 0, 8'h10, 8'hAA, "rst_wr");
    step(0, 0, 1, 8'h10, 8'h00, "rd10_after_rst");

    for (int i = 0; i < 256; i++) begin
      sweep_val[i] = spram_word_t'($urandom);
      step(0, 1, 0, 8'(i), sweep_val[i], "sweep_wr");
    end
    for (int i = 0; i < 256; i++) step(0, 0, 1, 8'(i), 8'h00, "sweep_rd");
    step(0, 0, 1, 8'hFF, 8'h00, "rdFF");
    step(0, 0, 1, 8'h00, 8'h00, "rd00_wrap");

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
           8'($urandom), spram_word_t'($urandom), "random");
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
